// File: rtl/rv32_pkg.sv
// Shared RV32 core types: load/store width codes, LSU states, writeback sources.
package rv32_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_BUS  = 2'b01,
        LSU_RESP = 2'b10
    } lsu_state_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_CSR = 2'b11
    } wb_source_t;

endpackage

// File: rtl/rv32_mod_lsu_align.sv
// LSU lane logic: byte enables, store replication, load lane select/extension.
// RV32_LSU_MISALIGN_CHECK_EN enables the misalignment flag.
module rv32_mod_lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [1:0]  lo;
    logic [31:0] sh;
    logic        sext;

    // Halfword/word offsets are truncated to their natural alignment
    always_comb begin
        lo        = 2'b00;
        be        = 4'b1111;
        wdata_rep = wdata;
        case (funct[1:0])
            LSU_B[1:0]: begin
                lo        = addr_lo;
                be        = 4'b0001 << lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            LSU_H[1:0]: begin
                lo        = {addr_lo[1], 1'b0};
                be        = 4'b0011 << lo;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                lo        = 2'b00;
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    assign sh   = rdata >> {lo, 3'b000};
    assign sext = ~funct[2];

    always_comb begin
        rdata_ext = sh;
        case (funct[1:0])
            LSU_B[1:0]: rdata_ext = {{24{sext & sh[7]}}, sh[7:0]};
            LSU_H[1:0]: rdata_ext = {{16{sext & sh[15]}}, sh[15:0]};
            default:    rdata_ext = sh;
        endcase
    end

`ifdef RV32_LSU_MISALIGN_CHECK_EN
    assign misalign = ((funct[1:0] == LSU_H[1:0]) & addr_lo[0])
                    | ((funct[1:0] == LSU_W[1:0]) & (|addr_lo));
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/rv32_mod_load_store_unit.sv
// RV32 load/store unit: single outstanding access with bus watchdog.
// RV32_LSU_MISALIGN_CHECK_EN turns misaligned H/W accesses into faults.
module rv32_mod_load_store_unit
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_funct,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam int unsigned CW =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    lsu_state_t    state_q, state_d;
    logic          wr_q;
    logic [2:0]    funct_q;
    logic [1:0]    lo_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [2:0]  sel_funct;
    logic [1:0]  sel_lo;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic [31:0] rext;
    logic        misalign;
    logic        accept;
    logic        illegal;
    logic        tmo;

    // Live request drives the lane logic while idle, latched copy afterwards
    assign sel_funct = (state_q == LSU_IDLE) ? req_funct : funct_q;
    assign sel_lo    = (state_q == LSU_IDLE) ? req_addr[1:0] : lo_q;

    rv32_mod_lsu_align u_align (
        .funct     (sel_funct),
        .addr_lo   (sel_lo),
        .wdata     (req_wdata),
        .rdata     (bus_rdata),
        .be        (be),
        .wdata_rep (wrep),
        .rdata_ext (rext),
        .misalign  (misalign)
    );

    assign illegal = !(req_funct inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU})
                   | (req_wr & req_funct[2])
                   | misalign;

    assign accept = (state_q == LSU_IDLE) & req_valid;
    assign tmo    = (state_q == LSU_BUS) & ~bus_ack & (TIMEOUT_CYCLES != 0)
                  & ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LSU_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (accept) state_d = illegal ? LSU_RESP : LSU_BUS;
            LSU_BUS:  if (bus_ack || tmo) state_d = LSU_RESP;
            LSU_RESP: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q      <= 1'b0;
            funct_q   <= 3'b000;
            lo_q      <= 2'b00;
            cnt_q     <= '0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
        end else if (accept) begin
            wr_q    <= req_wr;
            funct_q <= req_funct;
            lo_q    <= req_addr[1:0];
            cnt_q   <= '0;
            rdata_q <= 32'd0;
            err_q   <= illegal;
            if (!illegal) begin
                bus_req   <= 1'b1;
                bus_wr    <= req_wr;
                bus_addr  <= {req_addr[31:2], 2'b00};
                bus_be    <= be;
                bus_wdata <= wrep;
            end
        end else if (state_q == LSU_BUS) begin
            if (bus_ack || tmo) begin
                bus_req   <= 1'b0;
                bus_wr    <= 1'b0;
                bus_addr  <= 32'd0;
                bus_be    <= 4'd0;
                bus_wdata <= 32'd0;
                err_q     <= bus_ack ? bus_err : 1'b1;
                rdata_q   <= (!bus_ack || wr_q || bus_err) ? 32'd0 : rext;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign req_ready  = (state_q == LSU_IDLE);
    assign resp_valid = (state_q == LSU_RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;
    assign resp_err   = resp_valid & err_q;

endmodule
